// File: rtl/sap3_deserializer.sv
// SAP-3 serial link receiver: recovers WIDTH-bit LSB-first frames and flags bad stop bits.
// Optional even-parity bit and parity_err output are enabled by defining SAP3_DESER_PARITY_EN.
module sap3_deserializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
`ifdef SAP3_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam int H  = (CLKS_PER_BIT - 1) / 2;
`ifdef SAP3_DESER_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_H    = CW'(H);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(LAST);
    localparam logic [BW-1:0] BIT_DATA = BW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             meta_q, s_q, s_prev_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
`ifdef SAP3_DESER_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= 1'b1;
            s_q      <= 1'b1;
            s_prev_q <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef SAP3_DESER_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            meta_q   <= serial_in;
            s_q      <= meta_q;
            s_prev_q <= s_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
`ifdef SAP3_DESER_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SAP3_DESER_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (s_prev_q && !s_q) begin
                    // cnt tracks cycles since the edge; with H=0 the edge cycle is the sample point
                    cnt_d   = CNT_ONE;
                    bit_d   = '0;
`ifdef SAP3_DESER_PARITY_EN
                    par_d   = 1'b0;
`endif
                    state_d = (H == 0) ? S_DATA : S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_H) begin
                    cnt_d   = CNT_ONE;
                    state_d = s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = CNT_ONE;
                    if (bit_q < BIT_DATA) begin
                        shreg_d = {s_q, shreg_q[WIDTH-1:1]};
                    end
`ifdef SAP3_DESER_PARITY_EN
                    par_d = par_q ^ s_q;
`endif
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (!s_q) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
`ifdef SAP3_DESER_PARITY_EN
                    end else if (par_q) begin
                        perr_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BREAK: begin
                if (s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);
`ifdef SAP3_DESER_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sap3_deserializer.sv
// Testbench for sap3_deserializer: two instances (CLKS_PER_BIT 4 and 1) driven with directed and
// random frames; a frame-level model predicts each receive event and the held data word.
module tb_sap3_deserializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser4 = 1'b1;
    logic ser1 = 1'b1;

    logic [7:0] dout4, dout1;
    logic       valid4, valid1, ferr4, ferr1, busy4, busy1;
`ifdef SAP3_DESER_PARITY_EN
    logic       perr4, perr1;
`endif

    always #5 clk = ~clk;

    sap3_deserializer #(.WIDTH(8), .CLKS_PER_BIT(4)) u_d4 (
        .clk(clk), .rst(rst), .serial_in(ser4), .data_out(dout4),
        .data_valid(valid4), .frame_err(ferr4), .busy(busy4)
`ifdef SAP3_DESER_PARITY_EN
        , .parity_err(perr4)
`endif
    );

    sap3_deserializer #(.WIDTH(8), .CLKS_PER_BIT(1)) u_d1 (
        .clk(clk), .rst(rst), .serial_in(ser1), .data_out(dout1),
        .data_valid(valid1), .frame_err(ferr1), .busy(busy1)
`ifdef SAP3_DESER_PARITY_EN
        , .parity_err(perr1)
`endif
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int both   = 0;

    // event word: {instance is CPB4, kind (0 valid, 1 frame_err, 2 parity_err), data}
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];
    logic [7:0]  mdl4 = 8'h00;
    logic [7:0]  mdl1 = 8'h00;

    always @(negedge clk) begin
        if (valid4) got_q.push_back({1'b1, 2'd0, dout4});
        if (ferr4)  got_q.push_back({1'b1, 2'd1, 8'h00});
        if (valid1) got_q.push_back({1'b0, 2'd0, dout1});
        if (ferr1)  got_q.push_back({1'b0, 2'd1, 8'h00});
        if (valid4 && ferr4) both++;
        if (valid1 && ferr1) both++;
`ifdef SAP3_DESER_PARITY_EN
        if (perr4) got_q.push_back({1'b1, 2'd2, 8'h00});
        if (perr1) got_q.push_back({1'b0, 2'd2, 8'h00});
        if (perr4 && (valid4 || ferr4)) both++;
        if (perr1 && (valid1 || ferr1)) both++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int cpb, input logic b);
        if (cpb == 4) ser4 = b;
        else          ser1 = b;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic idle(input int cpb, input int n);
        if (cpb == 4) ser4 = 1'b1;
        else          ser1 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Frame-level rule: bad stop -> frame_err; bad parity -> parity_err; else word delivered.
    function automatic void expect_frame(input int cpb, input logic [7:0] d,
                                         input logic stop_b, input logic par_b);
        logic id;
        id = (cpb == 4);
        if (!stop_b) begin
            exp_q.push_back({id, 2'd1, 8'h00});
`ifdef SAP3_DESER_PARITY_EN
        end else if ((^d ^ par_b) == 1'b1) begin
            exp_q.push_back({id, 2'd2, 8'h00});
`endif
        end else begin
            exp_q.push_back({id, 2'd0, d});
            if (id) mdl4 = d;
            else    mdl1 = d;
        end
    endfunction

    task automatic send_frame(input int cpb, input logic [7:0] d,
                              input logic stop_b, input logic par_b);
        drive_bit(cpb, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(cpb, d[i]);
`ifdef SAP3_DESER_PARITY_EN
        drive_bit(cpb, par_b);
`endif
        drive_bit(cpb, stop_b);
        expect_frame(cpb, d, stop_b, par_b);
    endtask

    task automatic compare(input string tag);
        logic [10:0] e, g;
        check({tag, " event count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 11'h7FF;
            check({tag, " event"}, {21'd0, g}, {21'd0, e});
        end
        got_q.delete();
        check({tag, " data_out cpb4"}, {24'd0, dout4}, {24'd0, mdl4});
        check({tag, " data_out cpb1"}, {24'd0, dout1}, {24'd0, mdl1});
    endtask

    initial begin
        logic [7:0] d;
        logic       stop_b, par_b;
        int         cpb;

        repeat (3) @(negedge clk);
        check("reset data_out", {24'd0, dout4}, 32'd0);
        check("reset flags", {28'd0, valid4, ferr4, valid1, ferr1}, 32'd0);
        check("reset busy", {30'd0, busy4, busy1}, 32'd0);
        rst = 1'b0;
        idle(4, 4);

        send_frame(4, 8'hA5, 1'b1, ^8'hA5);
        idle(4, 20);
        compare("a5");
        check("a5 busy after", {31'd0, busy4}, 32'd0);

        send_frame(1, 8'h00, 1'b1, 1'b0);
        send_frame(1, 8'hFF, 1'b1, 1'b0);
        idle(1, 10);
        compare("back2back");

        ser4 = 1'b0;
        @(negedge clk);
        ser4 = 1'b1;
        repeat (7) @(negedge clk);
        check("glitch busy", {31'd0, busy4}, 32'd0);
        compare("glitch");

        send_frame(4, 8'h3C, 1'b1, ^8'h3C);
        idle(4, 8);
        compare("3c");
        send_frame(4, 8'h81, 1'b0, ^8'h81);
        repeat (20) @(negedge clk);
        check("break busy held", {31'd0, busy4}, 32'd1);
        compare("break");
        idle(4, 8);
        check("break busy released", {31'd0, busy4}, 32'd0);
        send_frame(4, 8'h42, 1'b1, ^8'h42);
        idle(4, 20);
        compare("42");

        // abort 0xF0 partway through data bit 3
        drive_bit(4, 1'b0);
        d = 8'hF0;
        for (int i = 0; i < 3; i++) drive_bit(4, d[i]);
        ser4 = d[3];
        repeat (2) @(negedge clk);
        check("busy before abort", {31'd0, busy4}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort data_out", {24'd0, dout4}, 32'd0);
        check("abort flags/busy", {29'd0, valid4, ferr4, busy4}, 32'd0);
        mdl4 = 8'h00;
        mdl1 = 8'h00;
        ser4 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(4, 12);
        compare("abort");
        send_frame(4, 8'h5A, 1'b1, ^8'h5A);
        idle(4, 20);
        compare("5a");

`ifdef SAP3_DESER_PARITY_EN
        send_frame(4, 8'h07, 1'b1, 1'b1);
        idle(4, 12);
        send_frame(4, 8'h07, 1'b1, 1'b0);
        idle(4, 20);
        compare("parity");
`endif

        for (int n = 0; n < 16; n++) begin
            cpb    = ($urandom % 2) ? 4 : 1;
            d      = 8'($urandom);
            stop_b = ($urandom % 5) != 0;
            par_b  = (^d) ^ (($urandom % 5) == 0);
            send_frame(cpb, d, stop_b, par_b);
            if (!stop_b) begin
                repeat ($urandom_range(0, 8)) @(negedge clk);
                idle(cpb, $urandom_range(2, 6));
            end else begin
                idle(cpb, $urandom_range(0, 3));
            end
        end
        idle(4, 30);
        compare("random");

        check("flags never simultaneous", both, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
